// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: load/start/pause requests in,
// MM:SS count plus status pulses out.
interface countdown_timer_if;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic [5:0] min;
  logic [5:0] sec;
  logic       running;
  logic       done;
  logic       load_err;

  modport master (
    output load, load_min, load_sec, start, pause,
    input  min, sec, running, done, load_err
  );

  modport slave (
    input  load, load_min, load_sec, start, pause,
    output min, sec, running, done, load_err
  );
endinterface

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with one-second prescaler and load/start/pause control.
// Optional AUTO_RELOAD_EN: on expiry, restart from the last valid load value.
//
// state   | meaning
// IDLE    | count loaded (or reset), waiting for start
// RUN     | prescaler advancing, count steps once per TICK_DIV cycles
// PAUSED  | count and prescaler frozen, start resumes
// EXPIRED | reached 00:00, held until a valid load
module countdown_timer #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input logic              clk,
  input logic              rst,
  countdown_timer_if.slave tmr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [25:0] PRESC_MAX = 26'(TICK_DIV - 1);

  state_t      state_q, state_d;
  logic [5:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [25:0] presc_q, presc_d;
  logic        done_q, done_d;
  logic        load_err_q, load_err_d;

  logic        load_ok;
  logic        cnt_zero;
  logic        last_step;
  logic [5:0]  step_min;
  logic [5:0]  step_sec;

`ifdef AUTO_RELOAD_EN
  logic [5:0]  reload_min_q, reload_min_d;
  logic [5:0]  reload_sec_q, reload_sec_d;
`endif

  assign load_ok   = (tmr.load_min <= 6'd59) && (tmr.load_sec <= 6'd59);
  assign cnt_zero  = (min_q == 6'd0) && (sec_q == 6'd0);
  assign last_step = (min_q == 6'd0) && (sec_q == 6'd1);
  assign step_sec  = (sec_q != 6'd0) ? sec_q - 6'd1 : 6'd59;
  assign step_min  = (sec_q != 6'd0) ? min_q :
                     ((min_q != 6'd0) ? min_q - 6'd1 : 6'd0);

  always_comb begin
    state_d    = state_q;
    min_d      = min_q;
    sec_d      = sec_q;
    presc_d    = presc_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_min_d = reload_min_q;
    reload_sec_d = reload_sec_q;
`endif

    if (tmr.load) begin
      // An invalid load still outranks start/pause in the same cycle.
      if (load_ok) begin
        min_d   = tmr.load_min;
        sec_d   = tmr.load_sec;
        presc_d = '0;
        state_d = IDLE;
`ifdef AUTO_RELOAD_EN
        reload_min_d = tmr.load_min;
        reload_sec_d = tmr.load_sec;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tmr.start && (state_q == IDLE || state_q == PAUSED) && !cnt_zero) begin
      state_d = RUN;
    end else if (tmr.pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (state_q == RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        if (last_step) begin
          done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
          min_d = reload_min_q;
          sec_d = reload_sec_q;
          if (reload_min_q == 6'd0 && reload_sec_q == 6'd0) begin
            state_d = EXPIRED;
          end
`else
          min_d   = 6'd0;
          sec_d   = 6'd0;
          state_d = EXPIRED;
`endif
        end else begin
          min_d = step_min;
          sec_d = step_sec;
        end
      end else begin
        presc_d = presc_q + 26'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      min_q      <= '0;
      sec_q      <= '0;
      presc_q    <= '0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

`ifdef AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reload_min_q <= '0;
      reload_sec_q <= '0;
    end else begin
      reload_min_q <= reload_min_d;
      reload_sec_q <= reload_sec_d;
    end
  end
`endif

  assign tmr.min      = min_q;
  assign tmr.sec      = sec_q;
  assign tmr.running  = (state_q == RUN);
  assign tmr.done     = done_q;
  assign tmr.load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer at TICK_DIV=4: stimulus queues expected
// output events (cycle, count, status); the monitor pops one per observed event.
module tb_countdown_timer;

  typedef struct {
    int         cyc;
    logic [5:0] m;
    logic [5:0] s;
    logic       r;
    logic       d;
    logic       e;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  bit   mon_en;
  ev_t  exp_q[$];

  logic [5:0] pmin, psec;
  logic       prun;

  countdown_timer_if tmr ();

  countdown_timer #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tmr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic void expect_ev(int c, int m, int s, bit r, bit d, bit e);
    ev_t ev;
    ev.cyc = c;
    ev.m   = 6'(m);
    ev.s   = 6'(s);
    ev.r   = r;
    ev.d   = d;
    ev.e   = e;
    exp_q.push_back(ev);
  endfunction

  // Monitor: any count/running change or any done/load_err pulse is an event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (tmr.min != pmin || tmr.sec != psec || tmr.running != prun || tmr.done || tmr.load_err) begin
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL unexpected_event cyc=%0d got %0d:%0d run=%b done=%b err=%b, required no event",
                   cyc, tmr.min, tmr.sec, tmr.running, tmr.done, tmr.load_err);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.m != tmr.min || e.s != tmr.sec || e.r != tmr.running ||
              e.d != tmr.done || e.e != tmr.load_err) begin
            n_fail = n_fail + 1;
            $display("FAIL event cyc=%0d %0d:%0d run=%b done=%b err=%b, required cyc=%0d %0d:%0d run=%b done=%b err=%b",
                     cyc, tmr.min, tmr.sec, tmr.running, tmr.done, tmr.load_err,
                     e.cyc, e.m, e.s, e.r, e.d, e.e);
          end
        end
      end
      pmin = tmr.min;
      psec = tmr.sec;
      prun = tmr.running;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks = n_checks + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_load(int m, int s);
    tmr.load_min = 6'(m);
    tmr.load_sec = 6'(s);
    tmr.load     = 1'b1;
    @(negedge clk);
    tmr.load     = 1'b0;
  endtask

  task automatic pulse_start();
    tmr.start = 1'b1;
    @(negedge clk);
    tmr.start = 1'b0;
  endtask

  task automatic pulse_pause();
    tmr.pause = 1'b1;
    @(negedge clk);
    tmr.pause = 1'b0;
  endtask

  int t;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    mon_en       = 1'b0;
    pmin         = '0;
    psec         = '0;
    prun         = 1'b0;
    rst          = 1'b0;
    tmr.load     = 1'b0;
    tmr.load_min = '0;
    tmr.load_sec = '0;
    tmr.start    = 1'b0;
    tmr.pause    = 1'b0;

    wait_cyc(3);
    check("reset_outputs", {tmr.min, tmr.sec, tmr.running, tmr.done, tmr.load_err}, 32'd0);
    rst    = 1'b1;
    mon_en = 1'b1;
    wait_cyc(2);

    // 00:02 runs out after 8 cycles in RUN, then EXPIRED ignores start.
    t = cyc;
    expect_ev(t+1, 0, 2, 0, 0, 0);
    expect_ev(t+2, 0, 2, 1, 0, 0);
    expect_ev(t+6, 0, 1, 1, 0, 0);
    expect_ev(t+10, 0, 0, 0, 1, 0);
    pulse_load(0, 2);
    pulse_start();
    wait_cyc(10);
    check("expired_running", {31'd0, tmr.running}, 32'd0);
    pulse_start();
    wait_cyc(3);

    // 01:00: first step borrows into 00:59, 60 steps / 240 cycles total.
    t = cyc;
    expect_ev(t+1, 1, 0, 0, 0, 0);
    expect_ev(t+2, 1, 0, 1, 0, 0);
    for (int k = 59; k >= 1; k--) expect_ev(t + 6 + 4*(59-k), 0, k, 1, 0, 0);
    expect_ev(t+242, 0, 0, 0, 1, 0);
    pulse_load(1, 0);
    pulse_start();
    wait_cyc(245);

    // Pause taken with prescaler at 2: resume steps 2 cycles after restart.
    t = cyc;
    expect_ev(t+1, 0, 5, 0, 0, 0);
    expect_ev(t+2, 0, 5, 1, 0, 0);
    expect_ev(t+6, 0, 4, 1, 0, 0);
    expect_ev(t+9, 0, 4, 0, 0, 0);
    expect_ev(t+30, 0, 4, 1, 0, 0);
    expect_ev(t+32, 0, 3, 1, 0, 0);
    expect_ev(t+36, 0, 2, 1, 0, 0);
    expect_ev(t+40, 0, 1, 1, 0, 0);
    expect_ev(t+44, 0, 0, 0, 1, 0);
    pulse_load(0, 5);
    pulse_start();
    wait_cyc(6);
    pulse_pause();
    wait_cyc(20);
    pulse_start();
    wait_cyc(16);

    // Pause coinciding with the final step wins; resume finishes one edge later.
    t = cyc;
    expect_ev(t+1, 0, 1, 0, 0, 0);
    expect_ev(t+2, 0, 1, 1, 0, 0);
    expect_ev(t+6, 0, 1, 0, 0, 0);
    expect_ev(t+7, 0, 1, 1, 0, 0);
    expect_ev(t+8, 0, 0, 0, 1, 0);
    pulse_load(0, 1);
    pulse_start();
    wait_cyc(3);
    pulse_pause();
    pulse_start();
    wait_cyc(5);

    // Rejected loads, start on 00:00, and the 59:59 boundary.
    t = cyc;
    expect_ev(t+1, 0, 7, 0, 0, 0);
    expect_ev(t+2, 0, 7, 0, 0, 1);
    expect_ev(t+3, 0, 7, 0, 0, 1);
    expect_ev(t+4, 0, 7, 1, 0, 0);
    expect_ev(t+5, 0, 7, 1, 0, 1);
    expect_ev(t+6, 0, 0, 0, 0, 0);
    expect_ev(t+8, 59, 59, 0, 0, 0);
    expect_ev(t+9, 0, 0, 0, 0, 0);
    pulse_load(0, 7);
    pulse_load(60, 3);
    pulse_load(5, 63);
    pulse_start();
    pulse_load(60, 0);
    pulse_load(0, 0);
    pulse_start();
    pulse_load(59, 59);
    pulse_load(0, 0);
    wait_cyc(10);
    check("zero_start_idle", {31'd0, tmr.running}, 32'd0);

`ifdef AUTO_RELOAD_EN
    t = cyc;
    expect_ev(t+1, 0, 2, 0, 0, 0);
    expect_ev(t+2, 0, 2, 1, 0, 0);
    for (int p = 0; p < 3; p++) begin
      expect_ev(t + 6 + 8*p, 0, 1, 1, 0, 0);
      expect_ev(t + 10 + 8*p, 0, 2, 1, 1, 0);
    end
    expect_ev(t+28, 0, 0, 0, 0, 0);
    pulse_load(0, 2);
    pulse_start();
    wait_cyc(25);
    pulse_load(0, 0);
    wait_cyc(5);
`endif

    // Asynchronous reset mid-RUN: immediate clear, no done, start afterwards ignored.
    t = cyc;
    expect_ev(t+1, 0, 3, 0, 0, 0);
    expect_ev(t+2, 0, 3, 1, 0, 0);
    pulse_load(0, 3);
    pulse_start();
    @(negedge clk);
    mon_en = 1'b0;
    #3 rst = 1'b0;
    #1 check("async_reset_clear", {tmr.min, tmr.sec, tmr.running, tmr.done, tmr.load_err}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_no_done", {31'd0, tmr.done}, 32'd0);
    end
    rst    = 1'b1;
    pmin   = '0;
    psec   = '0;
    prun   = 1'b0;
    mon_en = 1'b1;
    pulse_start();
    wait_cyc(10);
    check("post_reset_idle", {tmr.min, tmr.sec, tmr.running}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
